cls_countdown_frame: RTL and testbench

Upstream frame builder for the PmodCLS SPI transmitter on the countdown display path. Takes binary minutes/seconds from the countdown timer, converts them to two-digit ASCII, and assembles a 152-bit (19-byte) frame: cursor-home escape sequence plus the text "T-MINUS MM:SS". It drives `send_data`, `begin_transmission` and `slave_select` into the SPI transmitter and consumes its `end_transmission`. It also enforces the CLS power-up delay after reset and a deselect gap between frames.

---
 rtl/cls_pkg.sv | 66 ++++++
 rtl/cls_countdown_frame_bcd2_seq.sv | 36 +++
 rtl/cls_countdown_frame.sv | 140 ++++++++++++++
 tb/tb_cls_countdown_frame.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cls_pkg.sv
// Shared constants, state encoding and frame layout for the PmodCLS countdown frame builder.
package cls_pkg;

  // ASCII characters used in the frame
  localparam logic [7:0] ASCII_ESC    = 8'h1B;
  localparam logic [7:0] ASCII_LBRACK = 8'h5B;
  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_SEMI   = 8'h3B;
  localparam logic [7:0] ASCII_H      = 8'h48;
  localparam logic [7:0] ASCII_COLON  = 8'h3A;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_T      = 8'h54;
  localparam logic [7:0] ASCII_DASH   = 8'h2D;
  localparam logic [7:0] ASCII_M      = 8'h4D;
  localparam logic [7:0] ASCII_I      = 8'h49;
  localparam logic [7:0] ASCII_N      = 8'h4E;
  localparam logic [7:0] ASCII_U      = 8'h55;
  localparam logic [7:0] ASCII_S      = 8'h53;

  // Frame geometry: byte 0 sits in the top byte and is shifted out first
  localparam int FRAME_BYTES  = 19;
  localparam int PREFIX_BYTES = 14;

  // Fixed bytes 0..13: cursor-home escape followed by "T-MINUS "
  localparam logic [PREFIX_BYTES*8-1:0] FRAME_PREFIX = {
    ASCII_ESC, ASCII_LBRACK, ASCII_0, ASCII_SEMI, ASCII_0, ASCII_H,
    ASCII_T, ASCII_DASH, ASCII_M, ASCII_I, ASCII_N, ASCII_U, ASCII_S, ASCII_SPACE
  };

  // Byte positions of the variable part of the frame
  localparam int M1_IDX    = 14;
  localparam int M0_IDX    = 15;
  localparam int COLON_IDX = 16;
  localparam int S1_IDX    = 17;
  localparam int S0_IDX    = 18;

  function automatic int byte_lsb(input int idx);
    return (FRAME_BYTES - 1 - idx) * 8;
  endfunction

  localparam int M1_LSB    = byte_lsb(M1_IDX);
  localparam int M0_LSB    = byte_lsb(M0_IDX);
  localparam int COLON_LSB = byte_lsb(COLON_IDX);
  localparam int S1_LSB    = byte_lsb(S1_IDX);
  localparam int S0_LSB    = byte_lsb(S0_IDX);

  // Display limits and the BCD subtraction step
  localparam logic [6:0] MIN_LIMIT = 7'd99;
  localparam logic [6:0] SEC_LIMIT = 7'd59;
  localparam logic [6:0] BCD_STEP  = 7'd10;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASCII_0 + {4'd0, d};
  endfunction

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_CONVERT,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DESELECT
  } state_t;

endpackage

// File: rtl/cls_countdown_frame_bcd2_seq.sv
// Sequential binary to two-digit BCD converter with clamping, one subtract-10 per cycle.
module bcd2_seq
  import cls_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] value,
  input  logic [6:0] limit,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] rem;
  logic [3:0] tens_q;

  // Load the clamped value on start, then peel off tens until the remainder is a single digit
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem    <= '0;
      tens_q <= '0;
    end else if (start) begin
      rem    <= (value > limit) ? limit : value;
      tens_q <= '0;
    end else if (rem >= BCD_STEP) begin
      rem    <= rem - BCD_STEP;
      tens_q <= tens_q + 4'd1;
    end
  end

  assign done = (rem < BCD_STEP);
  assign tens = tens_q;
  assign ones = rem[3:0];

endmodule

// File: rtl/cls_countdown_frame.sv
// Builds the "T-MINUS MM:SS" frame for the PmodCLS SPI transmitter and sequences chip select.
module cls_countdown_frame
  import cls_pkg::*;
#(
  parameter int DATASIZE       = 152,
  parameter int POWERUP_CYCLES = 2_000_000,
  parameter int SS_GAP_CYCLES  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                update,
  input  logic [6:0]          minutes,
  input  logic [5:0]          seconds,
  input  logic                end_transmission,
  output logic [DATASIZE-1:0] send_data,
  output logic                begin_transmission,
  output logic                slave_select,
  output logic                busy,
  output logic                frame_done
);

  localparam int MAX_CNT = (POWERUP_CYCLES > SS_GAP_CYCLES) ? POWERUP_CYCLES : SS_GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               pending;
  logic               start_conv;
  logic               min_done;
  logic               sec_done;
  logic [3:0]         min_tens;
  logic [3:0]         min_ones;
  logic [3:0]         sec_tens;
  logic [3:0]         sec_ones;
  logic [DATASIZE-1:0] frame;

  // Conversion starts, and inputs are captured, on the IDLE to CONVERT transition
  assign start_conv = (state == ST_IDLE) && (update || pending);

  bcd2_seq u_min_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_conv),
    .value (minutes),
    .limit (MIN_LIMIT),
    .done  (min_done),
    .tens  (min_tens),
    .ones  (min_ones)
  );

  bcd2_seq u_sec_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_conv),
    .value ({1'b0, seconds}),
    .limit (SEC_LIMIT),
    .done  (sec_done),
    .tens  (sec_tens),
    .ones  (sec_ones)
  );

  // Next-state logic and state-decoded strobes to the SPI transmitter
  always_comb begin
    next_state         = state;
    begin_transmission = 1'b0;
    slave_select       = 1'b1;
    busy               = (state != ST_IDLE);
    unique case (state)
      ST_POWERUP: begin
        if (cnt == CNT_W'(POWERUP_CYCLES - 1)) next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (start_conv) next_state = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (min_done && sec_done) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        next_state = ST_START;
      end
      ST_START: begin
        slave_select       = 1'b0;
        begin_transmission = 1'b1;
        next_state         = ST_WAIT;
      end
      ST_WAIT: begin
        slave_select = 1'b0;
        if (end_transmission) next_state = ST_DESELECT;
      end
      ST_DESELECT: begin
        if (cnt == CNT_W'(SS_GAP_CYCLES - 1)) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_POWERUP;
      end
    endcase
  end

  // State register, delay counter, merged pending request and frame-complete pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_POWERUP;
      cnt        <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= next_state;
      if ((next_state == state) && ((state == ST_POWERUP) || (state == ST_DESELECT)))
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
      if (start_conv)
        pending <= 1'b0;
      else if (update && (state != ST_IDLE))
        pending <= 1'b1;
      frame_done <= (state == ST_WAIT) && end_transmission;
    end
  end

  // Assemble the frame from the fixed prefix and the converted digits
  always_comb begin
    frame                                  = '0;
    frame[DATASIZE-1 -: PREFIX_BYTES*8]    = FRAME_PREFIX;
    frame[M1_LSB +: 8]                     = digit_ascii(min_tens);
    frame[M0_LSB +: 8]                     = digit_ascii(min_ones);
    frame[COLON_LSB +: 8]                  = ASCII_COLON;
    frame[S1_LSB +: 8]                     = digit_ascii(sec_tens);
    frame[S0_LSB +: 8]                     = digit_ascii(sec_ones);
  end

  // The frame register only changes in LOAD so it is stable for the whole transfer
  always_ff @(posedge clk) begin
    if (!rst)
      send_data <= '0;
    else if (state == ST_LOAD)
      send_data <= frame;
  end

endmodule

// File: tb/tb_cls_countdown_frame.sv
// Directed self-checking bench for cls_countdown_frame with a hand-driven SPI transmitter.
module tb_cls_countdown_frame;

  localparam int P = 100;
  localparam int G = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         update = 1'b0;
  logic [6:0]   minutes = '0;
  logic [5:0]   seconds = '0;
  logic         end_transmission = 1'b0;
  logic [151:0] send_data;
  logic         begin_transmission;
  logic         slave_select;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_base = 0;

  cls_countdown_frame #(
    .DATASIZE       (152),
    .POWERUP_CYCLES (P),
    .SS_GAP_CYCLES  (G)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .update             (update),
    .minutes            (minutes),
    .seconds            (seconds),
    .end_transmission   (end_transmission),
    .send_data          (send_data),
    .begin_transmission (begin_transmission),
    .slave_select       (slave_select),
    .busy               (busy),
    .frame_done         (frame_done)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the bench itself gets stuck
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [151:0] actual, input logic [151:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference frame: prefix, clamped two-digit minutes and seconds
  function automatic logic [151:0] expFrame(input int m, input int s);
    logic [7:0]   b [19];
    logic [151:0] f;
    int mc;
    int sc;
    mc = (m > 99) ? 99 : m;
    sc = (s > 59) ? 59 : s;
    b = '{8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h30, 8'h48, 8'h54, 8'h2D, 8'h4D, 8'h49,
          8'h4E, 8'h55, 8'h53, 8'h20, 8'h00, 8'h00, 8'h3A, 8'h00, 8'h00};
    b[14] = 8'(8'h30 + mc / 10);
    b[15] = 8'(8'h30 + mc % 10);
    b[17] = 8'(8'h30 + sc / 10);
    b[18] = 8'(8'h30 + sc % 10);
    f = '0;
    for (int i = 0; i < 19; i++) f[151 - 8*i -: 8] = b[i];
    return f;
  endfunction

  // Single-cycle update request; called on a falling edge, returns one cycle later
  task automatic applyStimulus(input int m, input int s);
    update  = 1'b1;
    minutes = 7'(m);
    seconds = 6'(s);
    tick();
    update  = 1'b0;
  endtask

  task automatic waitBegin(input string tag, input int budget, output int waited);
    waited = 0;
    while (begin_transmission !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_begin_seen"}, begin_transmission, 1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  // Acts as the SPI transmitter: entered on the START cycle, returns on the first DESELECT cycle
  task automatic serveFrame(input string tag, input logic [151:0] exp, input int hold, input bit inject);
    bit ss_low;
    ss_low = 1'b1;
    checkOutput({tag, "_ss_start"}, slave_select, 0);
    tick();
    checkOutput({tag, "_begin_pulse"}, begin_transmission, 0);
    for (int i = 0; i < hold; i++) begin
      if (slave_select !== 1'b0) ss_low = 1'b0;
      if (inject && i < 6 && (i % 2) == 0) begin
        update  = 1'b1;
        minutes = 7'd1;
        seconds = 6'(i / 2);
      end else begin
        update = 1'b0;
      end
      tick();
    end
    update = 1'b0;
    if (slave_select !== 1'b0) ss_low = 1'b0;
    end_transmission = 1'b1;
    tick();
    end_transmission = 1'b0;
    checkOutput({tag, "_ss_wait"}, ss_low, 1);
    checkOutput({tag, "_frame_done"}, frame_done, 1);
    checkOutput({tag, "_ss_rise"}, slave_select, 1);
    checkOutput({tag, "_data"}, send_data, exp);
  endtask

  initial begin
    int  w;
    int  gap;
    bit  early;
    bit  extra;

    $display("[TB] starting cls_countdown_frame bench");
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("rst_send_data", send_data, 0);
    checkOutput("rst_ss", slave_select, 1);
    checkOutput("rst_begin", begin_transmission, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_frame_done", frame_done, 0);

    // Power-up: request at cycle 10 stays pending until the delay expires
    rst = 1'b1;
    rel_base = cyc;
    repeat (10) tick();
    applyStimulus(5, 7);
    checkOutput("powerup_busy", busy, 1);
    early = 1'b0;
    while ((cyc - rel_base) < P) begin
      if (begin_transmission) early = 1'b1;
      tick();
    end
    checkOutput("no_early_begin", early, 0);
    waitBegin("f1", 50, w);
    checkOutput("f1_begin_cycle", cyc - rel_base, 103);
    serveFrame("f1", expFrame(5, 7), 4, 1'b0);
    checkOutput("f1_byte0", send_data[151:144], 8'h1B);
    checkOutput("f1_byte18", send_data[7:0], 8'h37);
    tick();
    checkOutput("f1_done_pulse", frame_done, 0);
    waitIdle("f1", G + 10);

    // Longest conversion: 99:59
    applyStimulus(99, 59);
    waitBegin("f2", 30, w);
    checkOutput("f2_convert_len", w - 1, 10);
    serveFrame("f2", expFrame(99, 59), 3, 1'b0);
    checkOutput("f2_digits", send_data[39:0], 40'h39393A3539);
    waitIdle("f2", G + 10);

    // Clamping of out-of-range inputs
    applyStimulus(120, 63);
    waitBegin("f3", 30, w);
    checkOutput("f3_convert_len", w - 1, 10);
    serveFrame("f3", expFrame(99, 59), 3, 1'b0);
    checkOutput("f3_digits", send_data[39:0], 40'h39393A3539);
    waitIdle("f3", G + 10);

    // Uneven tens digits: 42:17 converts in 1 + 4 cycles
    applyStimulus(42, 17);
    waitBegin("f4", 30, w);
    checkOutput("f4_convert_len", w - 1, 5);
    serveFrame("f4", expFrame(42, 17), 2, 1'b0);
    waitIdle("f4", G + 10);

    // Three updates during WAIT merge into one follow-up frame with the latest value
    applyStimulus(2, 0);
    waitBegin("f5", 30, w);
    serveFrame("f5", expFrame(2, 0), 8, 1'b1);
    gap = 0;
    while (begin_transmission !== 1'b1 && gap < 200) begin
      if (slave_select) gap++;
      tick();
    end
    checkOutput("f5_gap", gap, G + 3);
    waitBegin("f6", 1, w);
    serveFrame("f6", expFrame(1, 2), 3, 1'b0);
    waitIdle("f6", G + 10);
    extra = 1'b0;
    repeat (30) begin
      if (begin_transmission) extra = 1'b1;
      tick();
    end
    checkOutput("no_extra_frame", extra, 0);

    // Reset in the middle of WAIT, followed by a stale end_transmission
    applyStimulus(3, 4);
    waitBegin("f7", 30, w);
    tick();
    tick();
    checkOutput("f7_in_wait_ss", slave_select, 0);
    rst = 1'b0;
    tick();
    checkOutput("midrst_ss", slave_select, 1);
    checkOutput("midrst_busy", busy, 1);
    checkOutput("midrst_begin", begin_transmission, 0);
    rst = 1'b1;
    end_transmission = 1'b1;
    tick();
    end_transmission = 1'b0;
    checkOutput("late_end_frame_done", frame_done, 0);
    checkOutput("late_end_ss", slave_select, 1);
    checkOutput("late_end_busy", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
